pixel_streamer: RTL and testbench

//  Frame source for the conv front end: reads an IMG_H x IMG_W 8-bit image from a sync frame RAM
//  and emits it as a raster pixel stream, inserting PADDING zero pixels on every border.

---
 rtl/pixel_streamer.sv | 164 ++++++++++++++++
 tb/tb_pixel_streamer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_streamer.sv
// Raster frame source: reads an image from a sync frame RAM and streams it
// with a zero border, valid/ready output with full-throughput backpressure.
module pixel_streamer #(
    parameter int IMG_W   = 28,
    parameter int IMG_H   = 28,
    parameter int PADDING = 1,
    parameter int ADDR_W  = $clog2(IMG_W * IMG_H)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_row_last,
    output logic              out_frame_last
);

    localparam int TW   = IMG_W + 2 * PADDING;
    localparam int TH   = IMG_H + 2 * PADDING;
    localparam int PC_W = $clog2(TW);
    localparam int PR_W = $clog2(TH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PR_W-1:0]   pr_q, pr_d;
    logic [ADDR_W-1:0] rowbase_q, rowbase_d;

    logic inf_vld_q, inf_pad_q, inf_rl_q, inf_fl_q;

    logic [1:0][7:0] fifo_d_q;
    logic [1:0]      fifo_rl_q;
    logic [1:0]      fifo_fl_q;
    logic            wr_q, rd_q;
    logic [1:0]      occ_q;

    logic            pop, push, issue;
    logic            pad_pos, img_row, last_col, last_row;
    logic [2:0]      pend;
    logic [PC_W-1:0] col_off;
    logic [ADDR_W-1:0] addr_cur;

    assign pop  = out_valid & out_ready;
    assign push = inf_vld_q;
    assign pend = {1'b0, occ_q} + {2'b00, inf_vld_q} - {2'b00, pop};

    assign issue = (state_q == S_RUN) && (pend < 3'd2);

    assign img_row  = (int'(pr_q) >= PADDING) && (int'(pr_q) < PADDING + IMG_H);
    assign pad_pos  = !img_row || (int'(pc_q) < PADDING)
                   || (int'(pc_q) >= PADDING + IMG_W);
    assign last_col = (pc_q == PC_W'(TW - 1));
    assign last_row = (pr_q == PR_W'(TH - 1));

    // Address is the image row base plus the column inside the border.
    assign col_off  = pc_q - PC_W'(PADDING);
    assign addr_cur = rowbase_q + ADDR_W'(col_off);

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign mem_rd_en = issue && !pad_pos;
    assign mem_addr  = mem_rd_en ? addr_cur : '0;

    assign out_valid      = (occ_q != 2'd0);
    assign out_data       = out_valid ? fifo_d_q[rd_q] : 8'h00;
    assign out_row_last   = out_valid && fifo_rl_q[rd_q];
    assign out_frame_last = out_valid && fifo_fl_q[rd_q];

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pr_d      = pr_q;
        rowbase_d = rowbase_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_RUN;
                    pc_d      = '0;
                    pr_d      = '0;
                    rowbase_d = '0;
                end
            end
            S_RUN: begin
                if (issue) begin
                    if (last_col) begin
                        pc_d = '0;
                        pr_d = pr_q + 1'b1;
                        if (img_row) begin
                            rowbase_d = rowbase_q + ADDR_W'(IMG_W);
                        end
                    end else begin
                        pc_d = pc_q + 1'b1;
                    end
                    if (last_col && last_row) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (pop && out_frame_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            pr_q      <= '0;
            rowbase_q <= '0;
            inf_vld_q <= 1'b0;
            inf_pad_q <= 1'b0;
            inf_rl_q  <= 1'b0;
            inf_fl_q  <= 1'b0;
            fifo_d_q  <= '0;
            fifo_rl_q <= '0;
            fifo_fl_q <= '0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            occ_q     <= 2'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pr_q      <= pr_d;
            rowbase_q <= rowbase_d;
            // Tag travels alongside the RAM read so pads stay in order.
            inf_vld_q <= issue;
            inf_pad_q <= issue && pad_pos;
            inf_rl_q  <= issue && last_col;
            inf_fl_q  <= issue && last_col && last_row;
            if (push) begin
                fifo_d_q[wr_q]  <= inf_pad_q ? 8'h00 : mem_rdata;
                fifo_rl_q[wr_q] <= inf_rl_q;
                fifo_fl_q[wr_q] <= inf_fl_q;
                wr_q            <= ~wr_q;
            end
            if (pop) begin
                rd_q <= ~rd_q;
            end
            occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_pixel_streamer.sv
// Scoreboard bench for pixel_streamer: 4x3 image, one-pixel border,
// random RAM contents and several backpressure patterns.
module tb_pixel_streamer;

    localparam int W    = 4;
    localparam int H    = 3;
    localparam int P    = 1;
    localparam int TW   = W + 2 * P;
    localparam int TH   = H + 2 * P;
    localparam int NPIX = TW * TH;
    localparam int NIMG = W * H;
    localparam int AW   = $clog2(NIMG);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          out_ready = 1'b0;
    logic [7:0]    mem_rdata = 8'h00;
    logic          busy, done, mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [7:0]    out_data;
    logic          out_valid, out_row_last, out_frame_last;

    pixel_streamer #(
        .IMG_W  (W),
        .IMG_H  (H),
        .PADDING(P)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .mem_rd_en     (mem_rd_en),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_row_last  (out_row_last),
        .out_frame_last(out_frame_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       rl;
        logic       fl;
        logic       img;
    } px_t;

    px_t        q[$];
    logic [7:0] ram[NIMG];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int mode = 0;
    int st = 0;
    int rd_cnt = 0;
    int img_popped = 0;
    int pix_idx = 0;
    int frames_done = 0;
    int first_cyc = 0;
    int frames_exp = 0;
    bit done_due = 0;
    bit stall_prev = 0;
    logic [7:0] p_d;
    logic p_rl, p_fl;
    logic l_en = 1'b0;
    logic [AW-1:0] l_addr = '0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference stream: padded raster scan of the RAM image.
    task automatic load_expected();
        for (int pr = 0; pr < TH; pr++) begin
            for (int pc = 0; pc < TW; pc++) begin
                px_t e;
                bit pad;
                pad = (pr < P) || (pr >= P + H) || (pc < P) || (pc >= P + W);
                e.img = !pad;
                e.d = 8'h00;
                if (!pad) e.d = ram[(pr - P) * W + (pc - P)];
                e.rl = (pc == TW - 1);
                e.fl = (pr == TH - 1) && (pc == TW - 1);
                q.push_back(e);
            end
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rd_en"}, mem_rd_en, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_data"}, out_data, 0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_rl"}, out_row_last, 0);
        chk({tag, "_fl"}, out_frame_last, 0);
    endtask

    task automatic run_frame(input int m, input bit poke);
        int r0, f0, n;
        mode = m;
        st = cyc + 6;
        load_expected();
        r0 = rd_cnt;
        f0 = frames_done;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("lat_edge0", out_valid, 0);
        @(posedge clk); #1;
        chk("lat_edge1", out_valid, 0);
        @(posedge clk); #1;
        chk("lat_edge2", out_valid, 1);
        if (poke) begin
            repeat (3) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        n = 0;
        while (!done && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("frame_done_in_time", done, 1);
        chk("frame_reads", rd_cnt - r0, NIMG);
        chk("queue_drained", q.size(), 0);
        @(posedge clk); #1;
        chk("idle_after_done", busy, 0);
        chk("frame_count", frames_done, f0 + 1);
        frames_exp++;
    endtask

    initial begin
        fork
            begin : drv
                forever begin
                    @(posedge clk); #1;
                    cyc++;
                    case (mode)
                        0: out_ready = 1'b1;
                        1: out_ready = !out_ready;
                        2: out_ready = 1'($urandom_range(0, 1));
                        default: out_ready = !(cyc >= st && cyc < st + 10);
                    endcase
                    if (l_en && int'(l_addr) < NIMG) mem_rdata = ram[l_addr];
                    else mem_rdata = 8'($urandom_range(0, 255));
                end
            end
            begin : mon
                forever begin
                    @(negedge clk);
                    l_en = mem_rd_en;
                    l_addr = mem_addr;
                    if (rst) begin
                        done_due = 0;
                        stall_prev = 0;
                        pix_idx = 0;
                        rd_cnt = 0;
                        img_popped = 0;
                        l_en = 1'b0;
                    end else begin
                        if (done_due) begin
                            chk("done_pulse", done, 1);
                            done_due = 0;
                        end else begin
                            chk("done_low", done, 0);
                        end
                        if (done) frames_done++;
                        if (stall_prev) begin
                            chk("hold_valid", out_valid, 1);
                            chk("hold_data", out_data, p_d);
                            chk("hold_rl", out_row_last, p_rl);
                            chk("hold_fl", out_frame_last, p_fl);
                        end
                        stall_prev = out_valid && !out_ready;
                        p_d = out_data;
                        p_rl = out_row_last;
                        p_fl = out_frame_last;
                        if (out_valid && out_ready) begin
                            if (q.size() == 0) begin
                                chk("unexpected_pixel", 1, 0);
                            end else begin
                                px_t e;
                                e = q.pop_front();
                                chk($sformatf("pix%0d_data", pix_idx), out_data, e.d);
                                chk($sformatf("pix%0d_rl", pix_idx), out_row_last, e.rl);
                                chk($sformatf("pix%0d_fl", pix_idx), out_frame_last, e.fl);
                                if (e.img) img_popped++;
                            end
                            if (pix_idx == 0) first_cyc = cyc;
                            if (out_frame_last) begin
                                done_due = 1;
                                if (mode == 0) chk("no_bubbles", cyc - first_cyc, NPIX - 1);
                                pix_idx = 0;
                            end else begin
                                pix_idx++;
                            end
                        end
                        if (mem_rd_en) begin
                            rd_cnt++;
                            chk("addr_range", int'(mem_addr) < NIMG, 1);
                        end
                        chk("outstanding_le2", (rd_cnt - img_popped) <= 2, 1);
                        if (mode == 3 && cyc >= st + 3 && cyc < st + 10)
                            chk("stall_no_read", mem_rd_en, 0);
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < NIMG; i++) ram[i] = 8'(i + 1);
        run_frame(0, 0);
        run_frame(0, 0);
        run_frame(1, 0);
        for (int i = 0; i < NIMG; i++) ram[i] = 8'($urandom_range(1, 255));
        run_frame(3, 0);
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < NIMG; i++) ram[i] = 8'($urandom_range(0, 255));
            run_frame(2, k == 1);
        end

        begin
            int f0, n;
            mode = 0;
            load_expected();
            f0 = frames_done;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            n = 0;
            while (pix_idx < 15 && n < 200) begin
                @(posedge clk); #1;
                n++;
            end
            chk("abort_point_reached", pix_idx >= 15, 1);
            rst = 1'b1;
            @(posedge clk); #1;
            check_zero("abort");
            q.delete();
            rst = 1'b0;
            repeat (10) @(posedge clk);
            #1;
            chk("no_done_after_abort", frames_done, f0);
            chk("idle_after_abort", busy, 0);
        end

        for (int i = 0; i < NIMG; i++) ram[i] = 8'($urandom_range(0, 255));
        run_frame(0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("total_frames", frames_done, frames_exp);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
